flash_boot_loader: RTL and testbench
====================================

FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 Parameter NUM_BYTES, default 16: bytes requested from the flash reader per load; range 1 to 65535.
REQ-002 Parameter LOAD_BASE_ADDR, default 0: memory address of the first loaded byte.
REQ-003 Parameter ADDR_WIDTH, default 19: width of mem_addr.
REQ-004 Port clock, input, 1: single clock, all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle load request.
REQ-007 Port flash_read_en, output, 1: enables the upstream flash reader.
REQ-008 Port flash_read_active, input, 1: the flash reader is streaming.
REQ-009 Port flash_tValid, input, 1: flash_tData is valid this cycle; there is no backpressure.
REQ-010 Port flash_tData, input, 8: byte from the flash reader.
REQ-011 Port mem_we, output, 1: memory write request.
REQ-012 Port mem_addr, output, ADDR_WIDTH: write address.
REQ-013 Port mem_wdata, output, 8: write data.
REQ-014 Port mem_ready, input, 1: memory accepts the write this cycle.
REQ-015 Port cpu_reset_n, output, 1: CPU reset; low until the load completes.
REQ-016 Port load_done, output, 1: load completed successfully.
REQ-017 Port load_error, output, 1: load aborted.
REQ-018 Port checksum, output, 16: running sum of the received bytes.

Function
REQ-019 The state machine SHALL have the states IDLE, REQUEST, LOAD, DRAIN, DONE and ERROR.
REQ-020 In IDLE, DONE or ERROR, start=1 SHALL do all of the following:
- move to REQUEST the next cycle;
- clear the byte counters, checksum, load_done and load_error;
- drive cpu_reset_n low.
REQ-021 start SHALL be ignored in REQUEST, LOAD and DRAIN.
REQ-022 flash_read_en SHALL be 1 exactly in REQUEST and LOAD.
REQ-023 REQUEST SHALL move to LOAD on the first cycle flash_read_active=1.
REQ-024 Each flash_tValid=1 cycle in REQUEST or LOAD SHALL do all of the following:
- push flash_tData into a 2-entry FIFO;
- add it, zero-extended, to checksum modulo 2^16;
- increment rx_count.
REQ-025 On the cycle rx_count reaches NUM_BYTES, the block SHALL move to DRAIN and deassert flash_read_en the next cycle.
REQ-026 A push SHALL be dropped and the block SHALL go to ERROR if the FIFO holds 2 entries and no pop occurs in the same cycle; a simultaneous push and pop when full is legal.
REQ-027 The block SHALL go to ERROR if flash_read_active falls in LOAD while rx_count < NUM_BYTES.
REQ-028 The block SHALL go to ERROR if flash_tValid=1 occurs in DRAIN.
REQ-029 mem_we SHALL be 1 whenever the FIFO is non-empty and the state is not ERROR.
REQ-030 While mem_we=1, mem_addr and mem_wdata SHALL be the FIFO head and SHALL stay stable until a cycle with mem_ready=1.
REQ-031 A cycle with mem_we=1 and mem_ready=1 SHALL pop the FIFO and increment wr_index.
REQ-032 mem_addr SHALL equal (LOAD_BASE_ADDR + wr_index) mod 2^ADDR_WIDTH, wrapping silently.
REQ-033 Minimum latency from flash_tValid to mem_we SHALL be 1 cycle.
REQ-034 DRAIN SHALL move to DONE when the FIFO is empty and wr_index = NUM_BYTES.
REQ-035 In DONE, load_done=1 and cpu_reset_n=1, both held until the next start or reset.
REQ-036 In ERROR, load_error=1, cpu_reset_n=0, mem_we=0 and flash_read_en=0; the FIFO is flushed.
REQ-037 checksum SHALL hold its final value in DONE and ERROR.

Reset
REQ-038 On reset=1 the block SHALL enter IDLE, flush the FIFO and zero all counters.
REQ-039 Reset values SHALL be: flash_read_en=0, mem_we=0, mem_addr=LOAD_BASE_ADDR, mem_wdata=0, cpu_reset_n=0, load_done=0, load_error=0, checksum=0.
REQ-040 A reset in any state, including mid-load, SHALL abort immediately with no further memory writes.

Verification
REQ-041 Nominal load: NUM_BYTES=16, mem_ready tied 1, bytes 0x01..0x10 streamed every 8 cycles -> 16 writes to addresses 0..15 with matching data, checksum=0x0088, load_done=1, cpu_reset_n=1.
REQ-042 Memory stall: mem_ready low for 10 cycles during the 3rd byte, bytes spaced 8 cycles apart -> mem_addr/mem_wdata stable during the stall, FIFO full with no overflow, all 16 bytes written in order, DONE reached.
REQ-043 Overflow: mem_ready held 0, three flash_tValid pulses -> load_error=1, flash_read_en=0, cpu_reset_n=0, no write ever accepted.
REQ-044 Early end: flash_read_active drops after 5 of 16 bytes -> ERROR, load_error=1, checksum equals the sum of the 5 bytes.
REQ-045 Wrap: ADDR_WIDTH=4, LOAD_BASE_ADDR=14, NUM_BYTES=4 -> writes go to addresses 14, 15, 0, 1.
REQ-046 Reset mid-load after 7 bytes, then start -> all outputs at reset values, then a clean full 16-byte reload ending in DONE.

Source files
------------

// File: rtl/flash_boot_loader_if.sv
// Flash-stream and memory-write signals of the boot loader.
// The loader drives the master side; the flash reader and memory sit on the slave side.
interface flash_boot_loader_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  flash_read_en;
    logic                  flash_read_active;
    logic                  flash_tValid;
    logic [7:0]            flash_tData;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_ready;

    modport master (
        output flash_read_en,
        input  flash_read_active,
        input  flash_tValid,
        input  flash_tData,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  flash_read_en,
        output flash_read_active,
        output flash_tValid,
        output flash_tData,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/flash_boot_loader.sv
// Copies NUM_BYTES from a flash byte stream into memory through a 2-entry FIFO,
// holding the CPU in reset until the whole image has been written.
module flash_boot_loader #(
    parameter int NUM_BYTES      = 16,
    parameter int LOAD_BASE_ADDR = 0,
    parameter int ADDR_WIDTH     = 19
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    flash_boot_loader_if.master bus,
    output logic                cpu_reset_n,
    output logic                load_done,
    output logic                load_error,
    output logic [15:0]         checksum
);
    typedef enum logic [2:0] {IDLE, REQUEST, LOAD, DRAIN, DONE, ERROR} state_t;

    state_t      state;
    logic [16:0] rx_count;
    logic [16:0] wr_index;
    logic [7:0]  fifo_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_count;

    logic in_rx;
    logic mem_we_int;
    logic pop;
    logic push_req;
    logic overflow;
    logic push;
    logic last_byte;
    logic abort;

    assign in_rx      = (state == REQUEST) || (state == LOAD);
    assign mem_we_int = (fifo_count != 2'd0) && (state != ERROR);
    assign pop        = mem_we_int && bus.mem_ready;
    assign push_req   = in_rx && bus.flash_tValid;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign overflow   = push_req && (fifo_count == 2'd2) && !pop;
    assign push       = push_req && !overflow;
    assign last_byte  = push && (rx_count == 17'(NUM_BYTES - 1));
    assign abort      = overflow
                     || ((state == LOAD) && !bus.flash_read_active && !last_byte)
                     || ((state == DRAIN) && bus.flash_tValid);

    assign bus.flash_read_en = in_rx;
    assign bus.mem_we        = mem_we_int;
    assign bus.mem_addr      = ADDR_WIDTH'(LOAD_BASE_ADDR) + ADDR_WIDTH'(wr_index);
    assign bus.mem_wdata     = mem_we_int ? fifo_mem[rd_ptr] : 8'h00;
    assign cpu_reset_n       = (state == DONE);
    assign load_done         = (state == DONE);
    assign load_error        = (state == ERROR);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.flash_tData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rx_count   <= '0;
            wr_index   <= '0;
            checksum   <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr   <= ~wr_ptr;
                rx_count <= rx_count + 17'd1;
                checksum <= checksum + {8'h00, bus.flash_tData};
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                wr_index <= wr_index + 17'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= REQUEST;
                        rx_count <= '0;
                        wr_index <= '0;
                        checksum <= '0;
                    end
                end
                REQUEST: begin
                    if (last_byte) begin
                        state <= DRAIN;
                    end else if (bus.flash_read_active) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (last_byte) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((fifo_count == 2'd0) && (wr_index == 17'(NUM_BYTES))) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Any abort discards whatever is still queued for memory.
            if (abort) begin
                state <= ERROR;
            end
            if (abort || (state == ERROR)) begin
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
                fifo_count <= 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench for flash_boot_loader: default instance for the load scenarios,
// a small 4-bit-address instance for address wrap.
module tb_flash_boot_loader;
    logic        clock = 1'b0;
    logic        reset;
    logic        start_a;
    logic        start_b;
    logic        cpu_reset_n_a, load_done_a, load_error_a;
    logic        cpu_reset_n_b, load_done_b, load_error_b;
    logic [15:0] checksum_a, checksum_b;

    flash_boot_loader_if #(.ADDR_WIDTH(19)) ifa();
    flash_boot_loader_if #(.ADDR_WIDTH(4))  ifb();

    flash_boot_loader #(.NUM_BYTES(16), .LOAD_BASE_ADDR(0), .ADDR_WIDTH(19)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .bus(ifa),
        .cpu_reset_n(cpu_reset_n_a), .load_done(load_done_a),
        .load_error(load_error_a), .checksum(checksum_a)
    );

    flash_boot_loader #(.NUM_BYTES(4), .LOAD_BASE_ADDR(14), .ADDR_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .bus(ifb),
        .cpu_reset_n(cpu_reset_n_b), .load_done(load_done_b),
        .load_error(load_error_b), .checksum(checksum_b)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    int          exp_idx;
    logic [15:0] exp_sum;
    int          wrap_addr[4] = '{14, 15, 0, 1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk_a(input int a, input logic [7:0] d);
        return {5'b0, a[18:0], d};
    endfunction

    function automatic logic [31:0] pk_b(input int a, input logic [7:0] d);
        return {20'b0, a[3:0], d};
    endfunction

    // Every accepted write is matched against the oldest expected (address, data) pair.
    always @(negedge clock) begin
        if (ifa.mem_we && ifa.mem_ready) begin
            wr_cnt_a++;
            if (qa.size() == 0) check_val("a_wr_qsize", qa.size(), 1);
            else check_val("a_wr", pk_a(int'(ifa.mem_addr), ifa.mem_wdata), qa.pop_front());
        end
        if (ifb.mem_we && ifb.mem_ready) begin
            wr_cnt_b++;
            if (qb.size() == 0) check_val("b_wr_qsize", qb.size(), 1);
            else check_val("b_wr", pk_b(int'(ifb.mem_addr), ifb.mem_wdata), qb.pop_front());
        end
    end

    task automatic pulse_start_a();
        @(posedge clock); #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d, input int gap, input bit expect_wr);
        @(posedge clock); #1;
        ifa.flash_tValid = 1'b1;
        ifa.flash_tData  = d;
        if (expect_wr) qa.push_back(pk_a(exp_idx, d));
        exp_idx++;
        exp_sum = exp_sum + {8'h00, d};
        @(posedge clock); #1 ifa.flash_tValid = 1'b0;
        repeat (gap - 2) @(posedge clock);
    endtask

    task automatic begin_load_a();
        wr_cnt_a = 0;
        exp_idx  = 0;
        exp_sum  = 16'h0;
        qa.delete();
        ifa.flash_read_active = 1'b1;
        pulse_start_a();
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (load_done_a !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check_val("a_done_timeout", load_done_a, 1);
    endtask

    task automatic check_reset_state_a();
        check_val("rst_read_en", ifa.flash_read_en, 0);
        check_val("rst_mem_we", ifa.mem_we, 0);
        check_val("rst_mem_addr", ifa.mem_addr, 0);
        check_val("rst_mem_wdata", ifa.mem_wdata, 0);
        check_val("rst_cpu_reset_n", cpu_reset_n_a, 0);
        check_val("rst_load_done", load_done_a, 0);
        check_val("rst_load_error", load_error_a, 0);
        check_val("rst_checksum", checksum_a, 0);
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ifa.flash_read_active = 1'b0; ifa.flash_tValid = 1'b0; ifa.flash_tData = 8'h00; ifa.mem_ready = 1'b1;
        ifb.flash_read_active = 1'b0; ifb.flash_tValid = 1'b0; ifb.flash_tData = 8'h00; ifb.mem_ready = 1'b1;
        exp_idx = 0; exp_sum = 16'h0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state_a();
        check_val("rst_b_mem_addr", ifb.mem_addr, 14);

        // Nominal load, with a stray start in the middle that must be ignored.
        begin_load_a();
        @(negedge clock);
        check_val("req_read_en", ifa.flash_read_en, 1);
        check_val("req_cpu_reset_n", cpu_reset_n_a, 0);
        for (int i = 1; i <= 16; i++) begin
            send_a(8'(i), 8, 1'b1);
            if (i == 3) pulse_start_a();
        end
        wait_done_a();
        check_val("nom_checksum", checksum_a, 16'h0088);
        check_val("nom_cpu_reset_n", cpu_reset_n_a, 1);
        check_val("nom_read_en", ifa.flash_read_en, 0);
        check_val("nom_load_error", load_error_a, 0);
        check_val("nom_writes", wr_cnt_a, 16);
        check_val("nom_q_left", qa.size(), 0);

        // Address wrap on the 4-bit instance.
        ifb.flash_read_active = 1'b1;
        @(posedge clock); #1 start_b = 1'b1;
        @(posedge clock); #1 start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            ifb.flash_tValid = 1'b1;
            ifb.flash_tData  = 8'(8'hA0 + i);
            qb.push_back(pk_b(wrap_addr[i], 8'(8'hA0 + i)));
            @(posedge clock); #1 ifb.flash_tValid = 1'b0;
            repeat (2) @(posedge clock);
        end
        repeat (10) @(negedge clock);
        check_val("wrap_done", load_done_b, 1);
        check_val("wrap_writes", wr_cnt_b, 4);
        check_val("wrap_q_left", qb.size(), 0);
        check_val("wrap_checksum", checksum_b, 16'h0286);

        // Memory stall across the third byte; the fourth byte fills the FIFO.
        begin_load_a();
        send_a(8'h01, 8, 1'b1);
        send_a(8'h02, 8, 1'b1);
        @(posedge clock); #1;
        ifa.mem_ready    = 1'b0;
        ifa.flash_tValid = 1'b1;
        ifa.flash_tData  = 8'h03;
        qa.push_back(pk_a(2, 8'h03));
        exp_idx = 3;
        exp_sum = exp_sum + 16'h3;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            ifa.flash_tValid = (c == 7);
            if (c == 7) begin
                ifa.flash_tData = 8'h04;
                qa.push_back(pk_a(3, 8'h04));
                exp_idx = 4;
                exp_sum = exp_sum + 16'h4;
            end
            @(negedge clock);
            check_val("stall_addr", ifa.mem_addr, 2);
            check_val("stall_data", ifa.mem_wdata, 8'h03);
        end
        check_val("stall_we", ifa.mem_we, 1);
        check_val("stall_no_err", load_error_a, 0);
        @(posedge clock); #1 ifa.mem_ready = 1'b1;
        for (int i = 5; i <= 16; i++) send_a(8'(i), 8, 1'b1);
        wait_done_a();
        check_val("stall_writes", wr_cnt_a, 16);
        check_val("stall_q_left", qa.size(), 0);
        check_val("stall_checksum", checksum_a, exp_sum);

        // Overflow: memory never ready, third byte has nowhere to go.
        ifa.mem_ready = 1'b0;
        begin_load_a();
        for (int i = 0; i < 3; i++) send_a(8'h11, 3, 1'b0);
        @(negedge clock);
        check_val("ovf_load_error", load_error_a, 1);
        check_val("ovf_read_en", ifa.flash_read_en, 0);
        check_val("ovf_cpu_reset_n", cpu_reset_n_a, 0);
        check_val("ovf_mem_we", ifa.mem_we, 0);
        @(posedge clock); #1 ifa.mem_ready = 1'b1;
        repeat (5) @(negedge clock);
        check_val("ovf_writes", wr_cnt_a, 0);

        // Flash stream stops after 5 of 16 bytes.
        begin_load_a();
        for (int i = 0; i < 5; i++) send_a(8'(8'h21 + i), 8, 1'b1);
        @(posedge clock); #1 ifa.flash_read_active = 1'b0;
        repeat (3) @(negedge clock);
        check_val("early_load_error", load_error_a, 1);
        check_val("early_checksum", checksum_a, exp_sum);
        check_val("early_cpu_reset_n", cpu_reset_n_a, 0);
        check_val("early_load_done", load_done_a, 0);
        check_val("early_writes", wr_cnt_a, 5);

        // Reset after 7 bytes, then a full reload.
        begin_load_a();
        for (int i = 0; i < 7; i++) send_a(8'(8'h40 + i), 8, 1'b1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state_a();
        check_val("midrst_writes", wr_cnt_a, 7);
        begin_load_a();
        for (int i = 0; i < 16; i++) send_a(8'(8'hF0 ^ (i * 7)), 4, 1'b1);
        wait_done_a();
        check_val("reload_writes", wr_cnt_a, 16);
        check_val("reload_q_left", qa.size(), 0);
        check_val("reload_checksum", checksum_a, exp_sum);
        check_val("reload_cpu_reset_n", cpu_reset_n_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
